// File: rtl/multiplier_arbiter_if.sv
// Requester/multiplier bus bundle for the shared-multiplier arbiter.
// The arbiter uses the slave modport; the requester/multiplier side uses master.
interface multiplier_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  hold;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_y;
  logic [NREQ-1:0]       res_valid;
  logic [2*WIDTH-1:0]    res_y;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, hold, mul_y,
    input  req_ready, mul_a, mul_b, res_valid, res_y, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, hold, mul_y,
    output req_ready, mul_a, mul_b, res_valid, res_y, busy
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier among NREQ
// requesters; a tag pipeline routes each product back as a one-cycle pulse.
module multiplier_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplier_arbiter_if.slave  bus
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW   = 2 * WIDTH;
  // One extra stage so the tag lines up with mul_y when it is sampled.
  localparam int unsigned NSTG = MUL_LAT + 1;

  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [NSTG-1:0]  tag_vld_q, tag_vld_d;
  logic [IDXW-1:0]  tag_idx_q [NSTG];
  logic [IDXW-1:0]  tag_idx_d [NSTG];
  logic [NREQ-1:0]  res_valid_q, res_valid_d;
  logic [PW-1:0]    res_y_q, res_y_d;

  logic [NREQ-1:0]  cand_c;
  logic [NREQ-1:0]  grant_c;
  logic [IDXW-1:0]  gidx_c;
  logic             found_c;
  logic             accept_c;
  logic [IDXW-1:0]  idx_c;
  logic [WIDTH-1:0] sel_a_c, sel_b_c;

  // Round-robin search starting at ptr, wrapping mod NREQ.
  always_comb begin
    cand_c  = (rst || bus.hold) ? '0 : bus.req_valid;
    grant_c = '0;
    gidx_c  = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = IDXW'((32'(ptr_q) + k) % NREQ);
      if (!found_c && cand_c[idx_c]) begin
        found_c        = 1'b1;
        grant_c[idx_c] = 1'b1;
        gidx_c         = idx_c;
      end
    end
  end

  assign accept_c = |grant_c;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_a_c = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_c = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    tag_vld_d   = {tag_vld_q[NSTG-2:0], accept_c};
    tag_idx_d[0] = gidx_c;
    for (int unsigned s = 1; s < NSTG; s++) begin
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    res_valid_d = '0;
    res_y_d     = res_y_q;

    if (accept_c) begin
      ptr_d   = (gidx_c == IDXW'(NREQ - 1)) ? '0 : gidx_c + 1'b1;
      mul_a_d = sel_a_c;
      mul_b_d = sel_b_c;
    end

    if (tag_vld_q[NSTG-1]) begin
      res_valid_d = NREQ'(1) << tag_idx_q[NSTG-1];
      res_y_d     = bus.mul_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      res_valid_q <= '0;
      res_y_q     <= '0;
      for (int unsigned s = 0; s < NSTG; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      for (int unsigned s = 0; s < NSTG; s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
    end
  end

  assign bus.req_ready = grant_c;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = res_y_q;
  assign bus.busy      = (|tag_vld_q) | (|res_valid_q);

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter: per-cycle vector table plus
// hand-written streaming and mid-flight reset sequences.
module tb_multiplier_arbiter;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multiplier_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  multiplier_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Pipelined multiplier: product appears MUL_LAT edges after operands change.
  logic [2*WIDTH-1:0] mpipe [MUL_LAT];
  initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    mpipe[0] <= (2*WIDTH)'(bus.mul_a) * (2*WIDTH)'(bus.mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_y = mpipe[MUL_LAT-1];

  typedef struct {
    logic [3:0]  v;
    logic [15:0] a;
    logic [15:0] b;
    logic        h;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [7:0]  ry;
    logic        busy;
    logic [3:0]  ma;
    logic [3:0]  mb;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] a,
                              input logic [15:0] b, input logic h,
                              input logic [3:0] rdy, input logic [3:0] rv,
                              input logic [7:0] ry, input logic busy,
                              input logic [3:0] ma, input logic [3:0] mb);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.h = h; t.rdy = rdy; t.rv = rv;
    t.ry = ry; t.busy = busy; t.ma = ma; t.mb = mb;
    return t;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] a,
                       input logic [15:0] b, input logic h);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.hold      = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] A1 = 16'h0003, B1 = 16'h0005;
  localparam logic [15:0] A2 = 16'h4321, B2 = 16'h3333;
  localparam logic [15:0] A3 = 16'h4320, B3 = 16'h333F;

  logic [3:0] sb [8];
  logic [7:0] sy [8];

  initial begin
    // Single requester, then all four, then hold, then a=0 boundary and wrap.
    tbl[0]  = mk(4'h1, A1, B1, 0, 4'h1, 4'h0,  0, 0, 4'd0, 4'd0);
    tbl[1]  = mk(4'h0, A1, B1, 0, 4'h0, 4'h0,  0, 1, 4'd3, 4'd5);
    tbl[2]  = mk(4'h0, A1, B1, 0, 4'h0, 4'h0,  0, 1, 4'd3, 4'd5);
    tbl[3]  = mk(4'h0, A1, B1, 0, 4'h0, 4'h0,  0, 1, 4'd3, 4'd5);
    tbl[4]  = mk(4'h0, A1, B1, 0, 4'h0, 4'h1, 15, 1, 4'd3, 4'd5);
    tbl[5]  = mk(4'h0, A1, B1, 0, 4'h0, 4'h0, 15, 0, 4'd3, 4'd5);
    tbl[6]  = mk(4'hF, A2, B2, 0, 4'h2, 4'h0, 15, 0, 4'd3, 4'd5);
    tbl[7]  = mk(4'hF, A2, B2, 0, 4'h4, 4'h0, 15, 1, 4'd2, 4'd3);
    tbl[8]  = mk(4'hF, A2, B2, 0, 4'h8, 4'h0, 15, 1, 4'd3, 4'd3);
    tbl[9]  = mk(4'hF, A2, B2, 0, 4'h1, 4'h0, 15, 1, 4'd4, 4'd3);
    tbl[10] = mk(4'h0, A2, B2, 0, 4'h0, 4'h2,  6, 1, 4'd1, 4'd3);
    tbl[11] = mk(4'h0, A2, B2, 0, 4'h0, 4'h4,  9, 1, 4'd1, 4'd3);
    tbl[12] = mk(4'h0, A2, B2, 0, 4'h0, 4'h8, 12, 1, 4'd1, 4'd3);
    tbl[13] = mk(4'h0, A2, B2, 0, 4'h0, 4'h1,  3, 1, 4'd1, 4'd3);
    tbl[14] = mk(4'h0, A2, B2, 0, 4'h0, 4'h0,  3, 0, 4'd1, 4'd3);
    tbl[15] = mk(4'h1, A2, B2, 0, 4'h1, 4'h0,  3, 0, 4'd1, 4'd3);
    tbl[16] = mk(4'hA, A2, B2, 1, 4'h0, 4'h0,  3, 1, 4'd1, 4'd3);
    tbl[17] = mk(4'hA, A2, B2, 1, 4'h0, 4'h0,  3, 1, 4'd1, 4'd3);
    tbl[18] = mk(4'hA, A2, B2, 1, 4'h0, 4'h0,  3, 1, 4'd1, 4'd3);
    tbl[19] = mk(4'hA, A2, B2, 0, 4'h2, 4'h1,  3, 1, 4'd1, 4'd3);
    tbl[20] = mk(4'h8, A2, B2, 0, 4'h8, 4'h0,  3, 1, 4'd2, 4'd3);
    tbl[21] = mk(4'h0, A2, B2, 0, 4'h0, 4'h0,  3, 1, 4'd4, 4'd3);
    tbl[22] = mk(4'h0, A2, B2, 0, 4'h0, 4'h0,  3, 1, 4'd4, 4'd3);
    tbl[23] = mk(4'h0, A2, B2, 0, 4'h0, 4'h2,  6, 1, 4'd4, 4'd3);
    tbl[24] = mk(4'h0, A2, B2, 0, 4'h0, 4'h8, 12, 1, 4'd4, 4'd3);
    tbl[25] = mk(4'h0, A2, B2, 0, 4'h0, 4'h0, 12, 0, 4'd4, 4'd3);
    tbl[26] = mk(4'hF, A3, B3, 0, 4'h1, 4'h0, 12, 0, 4'd4, 4'd3);
    tbl[27] = mk(4'h0, A3, B3, 0, 4'h0, 4'h0, 12, 1, 4'd0, 4'd15);
    tbl[28] = mk(4'h0, A3, B3, 0, 4'h0, 4'h0, 12, 1, 4'd0, 4'd15);
    tbl[29] = mk(4'h0, A3, B3, 0, 4'h0, 4'h0, 12, 1, 4'd0, 4'd15);
    tbl[30] = mk(4'h0, A3, B3, 0, 4'h0, 4'h1,  0, 1, 4'd0, 4'd15);
    tbl[31] = mk(4'h0, A3, B3, 0, 4'h0, 4'h0,  0, 0, 4'd0, 4'd15);

    sb = '{4'd15, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    sy = '{8'd225, 8'd15, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90, 8'd105};

    // Reset with all requesters valid: nothing granted, everything cleared.
    drive(4'hF, 16'hFFFF, 16'hFFFF, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", -1, 32'(bus.req_ready), 32'd0);
    chk("rst_rv",    -1, 32'(bus.res_valid), 32'd0);
    chk("rst_ry",    -1, 32'(bus.res_y),     32'd0);
    chk("rst_busy",  -1, 32'(bus.busy),      32'd0);
    chk("rst_ma",    -1, 32'(bus.mul_a),     32'd0);
    chk("rst_mb",    -1, 32'(bus.mul_b),     32'd0);
    rst = 1'b0;

    for (int r = 0; r < 32; r++) begin
      drive(tbl[r].v, tbl[r].a, tbl[r].b, tbl[r].h);
      #1;
      chk("ready", r, 32'(bus.req_ready), 32'(tbl[r].rdy));
      chk("res_v", r, 32'(bus.res_valid), 32'(tbl[r].rv));
      chk("res_y", r, 32'(bus.res_y),     32'(tbl[r].ry));
      chk("busy",  r, 32'(bus.busy),      32'(tbl[r].busy));
      chk("mul_a", r, 32'(bus.mul_a),     32'(tbl[r].ma));
      chk("mul_b", r, 32'(bus.mul_b),     32'(tbl[r].mb));
      tick();
    end

    // Req2 streams 8 back-to-back ops; ptr is 1 so req2 wins each cycle.
    for (int k = 0; k < 13; k++) begin
      if (k < 8) drive(4'h4, 16'h0F00, 16'(sb[k]) << 8, 1'b0);
      else       drive(4'h0, 16'h0F00, 16'h0000, 1'b0);
      #1;
      chk("str_ready", k, 32'(bus.req_ready), (k < 8) ? 32'd4 : 32'd0);
      if (k >= 4 && k < 12) begin
        chk("str_rv", k, 32'(bus.res_valid), 32'd4);
        chk("str_ry", k, 32'(bus.res_y),     32'(sy[k-4]));
      end else begin
        chk("str_rv", k, 32'(bus.res_valid), 32'd0);
      end
      if (k == 12) chk("str_busy", k, 32'(bus.busy), 32'd0);
      tick();
    end

    // Two accepts (ptr 3 -> req0, then req1), then reset drops both.
    drive(4'h3, 16'h0021, 16'h0033, 1'b0);
    #1;
    chk("rf_ready0", 0, 32'(bus.req_ready), 32'd1);
    tick();
    drive(4'h2, 16'h0021, 16'h0033, 1'b0);
    #1;
    chk("rf_ready1", 1, 32'(bus.req_ready), 32'd2);
    tick();
    drive(4'hF, 16'h0021, 16'h0033, 1'b0);
    rst = 1'b1;
    #1;
    chk("rf_ready_rst", 2, 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(4'h0, 16'h0021, 16'h0033, 1'b0);
    for (int s = 3; s < 9; s++) begin
      #1;
      chk("rf_rv",   s, 32'(bus.res_valid), 32'd0);
      chk("rf_ry",   s, 32'(bus.res_y),     32'd0);
      chk("rf_busy", s, 32'(bus.busy),      32'd0);
      chk("rf_ma",   s, 32'(bus.mul_a),     32'd0);
      chk("rf_mb",   s, 32'(bus.mul_b),     32'd0);
      tick();
    end
    drive(4'hF, 16'h0021, 16'h0033, 1'b0);
    #1;
    chk("rf_ptr0", 9, 32'(bus.req_ready), 32'd1);
    tick();
    drive(4'h0, 16'h0000, 16'h0000, 1'b0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
